// File: rtl/pipeline_hazard_control_if.sv
// Hazard-control bundle between the pipeline datapath and its sequencer.
// master: datapath side (drives hazard inputs, consumes enables/flushes/status).
// slave : sequencer side (consumes hazard inputs, drives enables/flushes/status).
interface pipeline_hazard_control_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
);
  // hazard inputs
  logic [REG_ADDR_WIDTH-1:0] id_reg_a_addr;
  logic [REG_ADDR_WIDTH-1:0] id_reg_b_addr;
  logic                      id_reg_a_used;
  logic                      id_reg_b_used;
  logic                      id_ex_mem_rd_en;
  logic                      id_ex_reg_wr_en;
  logic [REG_ADDR_WIDTH-1:0] id_ex_reg_wr_addr;
  logic                      ex_mem_select_new_pc;
  logic                      mem_wait_req;
  // pipe controls
  logic                      pc_wr_en;
  logic                      if_id_wr_en;
  logic                      if_id_flush;
  logic                      id_ex_bubble;
  logic                      ex_mem_wr_en;
  logic                      ex_mem_flush;
  // status
  logic [1:0]                state_out;
  logic [CNT_WIDTH-1:0]      stall_count;
  logic [CNT_WIDTH-1:0]      flush_count;
  logic                      timeout_err;

  modport master (
    output id_reg_a_addr, id_reg_b_addr, id_reg_a_used, id_reg_b_used,
           id_ex_mem_rd_en, id_ex_reg_wr_en, id_ex_reg_wr_addr,
           ex_mem_select_new_pc, mem_wait_req,
    input  pc_wr_en, if_id_wr_en, if_id_flush, id_ex_bubble, ex_mem_wr_en,
           ex_mem_flush, state_out, stall_count, flush_count, timeout_err
  );

  modport slave (
    input  id_reg_a_addr, id_reg_b_addr, id_reg_a_used, id_reg_b_used,
           id_ex_mem_rd_en, id_ex_reg_wr_en, id_ex_reg_wr_addr,
           ex_mem_select_new_pc, mem_wait_req,
    output pc_wr_en, if_id_wr_en, if_id_flush, id_ex_bubble, ex_mem_wr_en,
           ex_mem_flush, state_out, stall_count, flush_count, timeout_err
  );
endinterface

// File: rtl/pipeline_hazard_control.sv
// Purpose : execute-stage sequencer - load-use stalls, redirect squash, memory-wait freeze,
//           stall/flush statistics and a memory-wait watchdog.
// Latency : pipe controls are combinational from registered state + current inputs (0 cycles).
// Backpressure: mem_wait_req freezes every pipe enable; redirect/load-use are deferred, not lost.
// Ports   : clk, rst (async, active-high); hc (slave modport) carries hazard inputs,
//           pipe enables/flushes, state_out, stall_count, flush_count, timeout_err.
module pipeline_hazard_control #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FLUSH_CYCLES   = 1,
  parameter int WAIT_TIMEOUT   = 255,
  parameter int CNT_WIDTH      = 16
) (
  input logic                      clk,
  input logic                      rst,
  pipeline_hazard_control_if.slave hc
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t               state;
  logic                 resume_flush;   // MEM_WAIT was entered from FLUSH
  logic [2:0]           remaining;      // squash cycles still owed after the detect cycle
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;
  logic                 timeout;

  logic [REG_ADDR_WIDTH-1:0] wr_addr;
  logic                      load_use;
  logic                      flush_ctx;
  logic                      redirect;
  logic                      flush_tail;
  logic                      lu_stall;
  logic [CNT_WIDTH-1:0]      wait_nxt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign wr_addr = hc.id_ex_reg_wr_addr;

  always_comb begin
    load_use = hc.id_ex_mem_rd_en && hc.id_ex_reg_wr_en && (wr_addr != '0) &&
               ((hc.id_reg_a_used && (hc.id_reg_a_addr == wr_addr)) ||
                (hc.id_reg_b_used && (hc.id_reg_b_addr == wr_addr)));
    // Releasing MEM_WAIT evaluates the cycle as the state that was frozen.
    // Encoding 3 falls through here as RUN.
    flush_ctx  = (state == ST_FLUSH) || ((state == ST_MEM_WAIT) && resume_flush);
    redirect   = !hc.mem_wait_req && hc.ex_mem_select_new_pc;
    flush_tail = !hc.mem_wait_req && !hc.ex_mem_select_new_pc && flush_ctx;
    // Load-use is moot while squashing: the ID instruction is being flushed anyway.
    lu_stall   = !hc.mem_wait_req && !hc.ex_mem_select_new_pc && !flush_ctx && load_use;
    // The first frozen cycle (in RUN or FLUSH) counts as wait cycle 1.
    wait_nxt   = (state == ST_MEM_WAIT) ? sat_inc(wait_cnt) : CNT_WIDTH'(1);
  end

  always_comb begin
    hc.pc_wr_en     = 1'b1;
    hc.if_id_wr_en  = 1'b1;
    hc.if_id_flush  = 1'b0;
    hc.id_ex_bubble = 1'b0;
    hc.ex_mem_wr_en = 1'b1;
    hc.ex_mem_flush = 1'b0;
    if (hc.mem_wait_req) begin
      hc.pc_wr_en     = 1'b0;
      hc.if_id_wr_en  = 1'b0;
      hc.ex_mem_wr_en = 1'b0;
    end else if (redirect) begin
      hc.if_id_flush  = 1'b1;
      hc.id_ex_bubble = 1'b1;
      hc.ex_mem_flush = 1'b1;
    end else if (flush_tail) begin
      // Wrong-path work already past EX/MEM is gone; only the front end keeps squashing.
      hc.if_id_flush  = 1'b1;
      hc.id_ex_bubble = 1'b1;
    end else if (lu_stall) begin
      hc.pc_wr_en     = 1'b0;
      hc.if_id_wr_en  = 1'b0;
      hc.id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_RUN;
      resume_flush <= 1'b0;
      remaining    <= 3'd0;
      wait_cnt     <= '0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
      timeout      <= 1'b0;
    end else if (hc.mem_wait_req) begin
      state     <= ST_MEM_WAIT;
      wait_cnt  <= wait_nxt;
      stall_cnt <= sat_inc(stall_cnt);
      if (state != ST_MEM_WAIT) begin
        resume_flush <= (state == ST_FLUSH);
      end
      if (wait_nxt == CNT_WIDTH'(WAIT_TIMEOUT)) begin
        timeout <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
      if (redirect) begin
        flush_cnt <= sat_inc(flush_cnt);
        remaining <= 3'(FLUSH_CYCLES - 1);
        state     <= (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
      end else if (flush_tail) begin
        if (remaining <= 3'd1) begin
          remaining <= 3'd0;
          state     <= ST_RUN;
        end else begin
          remaining <= remaining - 3'd1;
          state     <= ST_FLUSH;
        end
      end else begin
        state <= ST_RUN;
        if (lu_stall) begin
          stall_cnt <= sat_inc(stall_cnt);
        end
      end
    end
  end

  assign hc.state_out   = state;
  assign hc.stall_count = stall_cnt;
  assign hc.flush_count = flush_cnt;
  assign hc.timeout_err = timeout;

endmodule

// File: tb/tb_pipeline_hazard_control.sv
// Two instances share one stimulus stream:
//   dut_a: FLUSH_CYCLES=3, WAIT_TIMEOUT=255, CNT_WIDTH=16
//   dut_b: FLUSH_CYCLES=1, WAIT_TIMEOUT=15,  CNT_WIDTH=4 (reaches counter saturation)
module tb_pipeline_hazard_control;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [4:0] wa;
    logic [4:0] a;
    logic [4:0] b;
    logic       au;
    logic       bu;
    logic       sel;
    logic       req;
  } in_t;

  typedef struct {
    in_t        in;
    logic [5:0] ea;
    logic [1:0] sa;
    logic [5:0] eb;
    logic [1:0] sb;
  } vec_t;

  // Model view: mode 0 run, 1 squashing, 2 frozen by memory.
  typedef struct {
    int mode;
    int left;
    bit resume_flush;
    int wcnt;
    int stall;
    int flush;
    bit tout;
  } mst_t;

  // {pc_wr_en, if_id_wr_en, if_id_flush, id_ex_bubble, ex_mem_wr_en, ex_mem_flush}
  localparam logic [5:0] NRM  = 6'b110010;
  localparam logic [5:0] FRZ  = 6'b000000;
  localparam logic [5:0] RDR  = 6'b111111;
  localparam logic [5:0] TAIL = 6'b111110;
  localparam logic [5:0] LUS  = 6'b000110;

  logic clk = 1'b0;
  logic rst;
  in_t  cur;
  int   checks = 0;
  int   passes = 0;
  mst_t sa, sb, na, nb, s0;
  logic [5:0] ctl_a, ctl_b, da, db;
  logic [1:0] dsa, dsb;

  always #5 clk = ~clk;

  pipeline_hazard_control_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) ifa ();
  pipeline_hazard_control_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(4))  ifb ();

  assign ifa.id_reg_a_addr = cur.a;        assign ifb.id_reg_a_addr = cur.a;
  assign ifa.id_reg_b_addr = cur.b;        assign ifb.id_reg_b_addr = cur.b;
  assign ifa.id_reg_a_used = cur.au;       assign ifb.id_reg_a_used = cur.au;
  assign ifa.id_reg_b_used = cur.bu;       assign ifb.id_reg_b_used = cur.bu;
  assign ifa.id_ex_mem_rd_en = cur.rd;     assign ifb.id_ex_mem_rd_en = cur.rd;
  assign ifa.id_ex_reg_wr_en = cur.wr;     assign ifb.id_ex_reg_wr_en = cur.wr;
  assign ifa.id_ex_reg_wr_addr = cur.wa;   assign ifb.id_ex_reg_wr_addr = cur.wa;
  assign ifa.ex_mem_select_new_pc = cur.sel;
  assign ifb.ex_mem_select_new_pc = cur.sel;
  assign ifa.mem_wait_req = cur.req;       assign ifb.mem_wait_req = cur.req;

  assign ctl_a = {ifa.pc_wr_en, ifa.if_id_wr_en, ifa.if_id_flush, ifa.id_ex_bubble,
                  ifa.ex_mem_wr_en, ifa.ex_mem_flush};
  assign ctl_b = {ifb.pc_wr_en, ifb.if_id_wr_en, ifb.if_id_flush, ifb.id_ex_bubble,
                  ifb.ex_mem_wr_en, ifb.ex_mem_flush};

  pipeline_hazard_control #(.REG_ADDR_WIDTH(5), .FLUSH_CYCLES(3), .WAIT_TIMEOUT(255),
                            .CNT_WIDTH(16))
    dut_a (.clk(clk), .rst(rst), .hc(ifa));
  pipeline_hazard_control #(.REG_ADDR_WIDTH(5), .FLUSH_CYCLES(1), .WAIT_TIMEOUT(15),
                            .CNT_WIDTH(4))
    dut_b (.clk(clk), .rst(rst), .hc(ifb));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passes++;
  endtask

  function automatic int imin(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  function automatic in_t mk(input logic rd, input logic wr, input int wa, input int a,
                             input int b, input logic au, input logic bu,
                             input logic sel, input logic req);
    in_t r;
    r.rd = rd; r.wr = wr; r.wa = 5'(wa); r.a = 5'(a); r.b = 5'(b);
    r.au = au; r.bu = bu; r.sel = sel; r.req = req;
    return r;
  endfunction

  // One cycle of the pipeline rules: what the controls must be, and what the
  // bookkeeping looks like after the clock edge.
  function automatic void model_step(input mst_t s, input in_t i, input int fc, input int wt,
                                     input int cw, output mst_t n, output logic [5:0] ctl);
    int  maxc;
    int  ctx;
    bit  lu;
    maxc = (1 << cw) - 1;
    n    = s;
    lu   = i.rd && i.wr && (i.wa != 0) &&
           ((i.au && i.a == i.wa) || (i.bu && i.b == i.wa));
    ctx  = s.mode;
    if (ctx == 2 && !i.req) ctx = s.resume_flush ? 1 : 0;
    if (i.req) begin
      ctl     = FRZ;
      n.stall = imin(s.stall + 1, maxc);
      if (s.mode != 2) begin
        n.resume_flush = (s.mode == 1);
        n.wcnt = 1;
      end else begin
        n.wcnt = imin(s.wcnt + 1, maxc);
      end
      if (n.wcnt == wt) n.tout = 1'b1;
      n.mode = 2;
    end else if (i.sel) begin
      ctl     = RDR;
      n.flush = imin(s.flush + 1, maxc);
      n.left  = fc - 1;
      n.mode  = (n.left > 0) ? 1 : 0;
    end else if (ctx == 1) begin
      ctl    = TAIL;
      n.left = s.left - 1;
      n.mode = (n.left > 0) ? 1 : 0;
    end else if (lu) begin
      ctl     = LUS;
      n.stall = imin(s.stall + 1, maxc);
      n.mode  = 0;
    end else begin
      ctl    = NRM;
      n.mode = 0;
    end
  endfunction

  task automatic check_dut(input mst_t ea_s, input logic [5:0] ea, input mst_t eb_s,
                           input logic [5:0] eb);
    chk("a_ctl", 32'(ctl_a), 32'(ea));
    chk("a_state", 32'(ifa.state_out), 32'(ea_s.mode));
    chk("a_stall", 32'(ifa.stall_count), 32'(ea_s.stall));
    chk("a_flush", 32'(ifa.flush_count), 32'(ea_s.flush));
    chk("a_tout", 32'(ifa.timeout_err), 32'(ea_s.tout));
    chk("b_ctl", 32'(ctl_b), 32'(eb));
    chk("b_state", 32'(ifb.state_out), 32'(eb_s.mode));
    chk("b_stall", 32'(ifb.stall_count), 32'(eb_s.stall));
    chk("b_flush", 32'(ifb.flush_count), 32'(eb_s.flush));
    chk("b_tout", 32'(ifb.timeout_err), 32'(eb_s.tout));
  endtask

  task automatic cycle(input in_t v, output logic [5:0] ga, output logic [1:0] gsa,
                       output logic [5:0] gb, output logic [1:0] gsb);
    logic [5:0] ea, eb;
    cur = v;
    @(negedge clk);
    model_step(sa, v, 3, 255, 16, na, ea);
    model_step(sb, v, 1, 15, 4, nb, eb);
    check_dut(sa, ea, sb, eb);
    ga = ctl_a; gsa = ifa.state_out; gb = ctl_b; gsb = ifb.state_out;
    @(posedge clk);
    sa = na;
    sb = nb;
    #1;
  endtask

  vec_t tbl[29];

  initial begin
    in_t idle, sel1, req1, all3, sellu, lu4, v;
    s0 = '{default: 0};
    sa = s0;
    sb = s0;
    idle  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    sel1  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
    req1  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    all3  = mk(1, 1, 4, 4, 0, 1, 0, 1, 1);
    sellu = mk(1, 1, 4, 4, 0, 1, 0, 1, 0);
    lu4   = mk(1, 1, 4, 4, 0, 1, 0, 0, 0);

    tbl[0]  = '{idle,                          NRM,  2'd0, NRM, 2'd0};
    tbl[1]  = '{mk(1, 1, 3, 3, 0, 1, 0, 0, 0), LUS,  2'd0, LUS, 2'd0};
    tbl[2]  = '{idle,                          NRM,  2'd0, NRM, 2'd0};
    tbl[3]  = '{mk(1, 1, 0, 0, 0, 1, 0, 0, 0), NRM,  2'd0, NRM, 2'd0};
    tbl[4]  = '{mk(1, 1, 3, 3, 3, 0, 0, 0, 0), NRM,  2'd0, NRM, 2'd0};
    tbl[5]  = '{mk(1, 1, 7, 0, 7, 0, 1, 0, 0), LUS,  2'd0, LUS, 2'd0};
    tbl[6]  = '{mk(1, 0, 7, 0, 7, 0, 1, 0, 0), NRM,  2'd0, NRM, 2'd0};
    tbl[7]  = '{sel1,                          RDR,  2'd0, RDR, 2'd0};
    tbl[8]  = '{idle,                          TAIL, 2'd1, NRM, 2'd0};
    tbl[9]  = '{idle,                          TAIL, 2'd1, NRM, 2'd0};
    tbl[10] = '{idle,                          NRM,  2'd0, NRM, 2'd0};
    tbl[11] = '{sel1,                          RDR,  2'd0, RDR, 2'd0};
    tbl[12] = '{req1,                          FRZ,  2'd1, FRZ, 2'd0};
    tbl[13] = '{req1,                          FRZ,  2'd2, FRZ, 2'd2};
    tbl[14] = '{idle,                          TAIL, 2'd2, NRM, 2'd2};
    tbl[15] = '{idle,                          TAIL, 2'd1, NRM, 2'd0};
    tbl[16] = '{idle,                          NRM,  2'd0, NRM, 2'd0};
    tbl[17] = '{all3,                          FRZ,  2'd0, FRZ, 2'd0};
    tbl[18] = '{all3,                          FRZ,  2'd2, FRZ, 2'd2};
    tbl[19] = '{sellu,                         RDR,  2'd2, RDR, 2'd2};
    tbl[20] = '{idle,                          TAIL, 2'd1, NRM, 2'd0};
    tbl[21] = '{idle,                          TAIL, 2'd1, NRM, 2'd0};
    tbl[22] = '{idle,                          NRM,  2'd0, NRM, 2'd0};
    tbl[23] = '{sel1,                          RDR,  2'd0, RDR, 2'd0};
    tbl[24] = '{lu4,                           TAIL, 2'd1, LUS, 2'd0};
    tbl[25] = '{sel1,                          RDR,  2'd1, RDR, 2'd0};
    tbl[26] = '{idle,                          TAIL, 2'd1, NRM, 2'd0};
    tbl[27] = '{idle,                          TAIL, 2'd1, NRM, 2'd0};
    tbl[28] = '{idle,                          NRM,  2'd0, NRM, 2'd0};

    // Reset state
    rst = 1'b0;
    cur = idle;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_a_ctl", 32'(ctl_a), 32'(NRM));
    chk("rst_a_state", 32'(ifa.state_out), 32'd0);
    chk("rst_a_stall", 32'(ifa.stall_count), 32'd0);
    chk("rst_a_flush", 32'(ifa.flush_count), 32'd0);
    chk("rst_a_tout", 32'(ifa.timeout_err), 32'd0);
    chk("rst_b_ctl", 32'(ctl_b), 32'(NRM));
    chk("rst_b_state", 32'(ifb.state_out), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors: load-use, redirect squash, freeze priority and resume
    for (int r = 0; r < 29; r++) begin
      cycle(tbl[r].in, da, dsa, db, dsb);
      chk($sformatf("vec%0d_a_ctl", r), 32'(da), 32'(tbl[r].ea));
      chk($sformatf("vec%0d_a_state", r), 32'(dsa), 32'(tbl[r].sa));
      chk($sformatf("vec%0d_b_ctl", r), 32'(db), 32'(tbl[r].eb));
      chk($sformatf("vec%0d_b_state", r), 32'(dsb), 32'(tbl[r].sb));
    end
    chk("vec_a_stall_total", 32'(ifa.stall_count), 32'd6);
    chk("vec_a_flush_total", 32'(ifa.flush_count), 32'd5);
    chk("vec_b_stall_total", 32'(ifb.stall_count), 32'd7);
    chk("vec_b_flush_total", 32'(ifb.flush_count), 32'd5);

    // Long memory wait: watchdog, counter saturation, async reset mid-wait
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sa = s0;
    sb = s0;
    for (int k = 1; k <= 300; k++) begin
      if (k == 15)  chk("b_tout_before", 32'(ifb.timeout_err), 32'd0);
      if (k == 16)  chk("b_tout_at_limit", 32'(ifb.timeout_err), 32'd1);
      if (k == 20)  chk("b_stall_saturated", 32'(ifb.stall_count), 32'd15);
      if (k == 255) chk("a_tout_before", 32'(ifa.timeout_err), 32'd0);
      if (k == 255) chk("a_stall_254", 32'(ifa.stall_count), 32'd254);
      if (k == 256) chk("a_tout_at_limit", 32'(ifa.timeout_err), 32'd1);
      if (k == 289) chk("a_tout_held", 32'(ifa.timeout_err), 32'd1);
      if (k == 290) begin
        rst = 1'b1;
        #1;
        chk("midrst_a_state", 32'(ifa.state_out), 32'd0);
        chk("midrst_a_tout", 32'(ifa.timeout_err), 32'd0);
        chk("midrst_a_stall", 32'(ifa.stall_count), 32'd0);
        chk("midrst_b_tout", 32'(ifb.timeout_err), 32'd0);
        chk("midrst_b_stall", 32'(ifb.stall_count), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        sa = s0;
        sb = s0;
      end
      cycle(req1, da, dsa, db, dsb);
    end
    for (int k = 0; k < 4; k++) cycle(idle, da, dsa, db, dsb);

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      v.rd  = 1'($urandom_range(0, 1));
      v.wr  = 1'($urandom_range(0, 1));
      v.wa  = 5'($urandom_range(0, 3));
      v.a   = 5'($urandom_range(0, 3));
      v.b   = 5'($urandom_range(0, 3));
      v.au  = 1'($urandom_range(0, 1));
      v.bu  = 1'($urandom_range(0, 1));
      v.sel = ($urandom_range(0, 99) < 15);
      v.req = ($urandom_range(0, 99) < 20);
      cycle(v, da, dsa, db, dsb);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
